hazard_forward_unit: RTL and testbench



---
 rtl/hazard_forward_unit.sv | 136 +++++++++++++
 tb/tb_hazard_forward_unit.sv | 373 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_forward_unit.sv
// -----------------------------------------------------------------------------
// hazard_forward_unit
//
// Hazard detection and operand forwarding for the pipelined RV32 core. Sits
// between decode and the decode->execute register. A small scoreboard of
// FWD_DEPTH slots mirrors the destination register of every in-flight
// instruction (slot 0 = execute, slot 1 = memory, slot 2 = writeback for the
// default depth). For each source operand, the youngest matching producer
// supplies the value. If there is no match, the register file supplies it.
// A load whose data is not yet available raises a load-use stall.
//
// Ports
//   clk, rst            clock, asynchronous active-high reset
//   i_dec_valid         decode holds a valid instruction
//   i_dec_rs_addr       NUM_SRC packed source register addresses
//   i_dec_rs_used       per-source "operand is actually read"
//   i_dec_rd_addr       destination register of the decode instruction
//   i_dec_rd_we         decode instruction writes rd
//   i_dec_is_load       decode instruction is a load
//   i_flush             kill the instruction in decode (taken branch/jump)
//   i_rf_read_data      NUM_SRC packed register-file read values
//   i_stage_data        FWD_DEPTH packed results, one per in-flight slot
//   o_operand_data      NUM_SRC packed resolved operands (combinational)
//   o_fwd_sel           per source: 0 = register file, k = slot k-1
//   o_stall             hold fetch/decode and insert a bubble
//   o_issue             decode instruction enters execute this cycle
//   o_stall_cycles      saturating count of stalled cycles
// -----------------------------------------------------------------------------
module hazard_forward_unit #(
    parameter int XLEN             = 32,
    parameter int REGISTER_SIZE    = 5,
    parameter int NUM_SRC          = 2,
    parameter int FWD_DEPTH        = 3,
    parameter int LOAD_READY_STAGE = 1,
    localparam int SEL_W           = $clog2(FWD_DEPTH + 1)
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             i_dec_valid,
    input  logic [NUM_SRC*REGISTER_SIZE-1:0] i_dec_rs_addr,
    input  logic [NUM_SRC-1:0]               i_dec_rs_used,
    input  logic [REGISTER_SIZE-1:0]         i_dec_rd_addr,
    input  logic                             i_dec_rd_we,
    input  logic                             i_dec_is_load,
    input  logic                             i_flush,
    input  logic [NUM_SRC*XLEN-1:0]          i_rf_read_data,
    input  logic [FWD_DEPTH*XLEN-1:0]        i_stage_data,
    output logic [NUM_SRC*XLEN-1:0]          o_operand_data,
    output logic [NUM_SRC*SEL_W-1:0]         o_fwd_sel,
    output logic                             o_stall,
    output logic                             o_issue,
    output logic [31:0]                      o_stall_cycles
);

    // Scoreboard: one entry per in-flight slot, slot 0 is the youngest.
    logic                     r_slot_valid   [FWD_DEPTH];
    logic [REGISTER_SIZE-1:0] r_slot_rd      [FWD_DEPTH];
    logic                     r_slot_we      [FWD_DEPTH];
    logic                     r_slot_is_load [FWD_DEPTH];
    logic [31:0]              r_stall_cycles;

    logic [NUM_SRC-1:0]       w_src_hazard;
    logic                     w_any_hazard;
    logic                     w_stall;
    logic                     w_issue;

    // -------------------------------------------------------------------------
    // Operand resolution. The slot loop runs from oldest to youngest, so the
    // last match written is the youngest producer. Only the winning slot's
    // readiness decides the hazard. An older ready copy of the same register
    // must not mask a younger load that is still pending.
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every output of this block gets a default before any
        // conditional assignment, so no path can leave a latch behind.
        o_operand_data = i_rf_read_data;
        o_fwd_sel      = '0;
        w_src_hazard   = '0;
        for (int j = 0; j < NUM_SRC; j++) begin
            for (int i = FWD_DEPTH - 1; i >= 0; i--) begin
                if (r_slot_valid[i] && r_slot_we[i] && i_dec_rs_used[j] &&
                    (r_slot_rd[i] != '0) &&
                    (r_slot_rd[i] == i_dec_rs_addr[j*REGISTER_SIZE +: REGISTER_SIZE])) begin
                    o_fwd_sel[j*SEL_W +: SEL_W]  = SEL_W'(i + 1);
                    o_operand_data[j*XLEN +: XLEN] = i_stage_data[i*XLEN +: XLEN];
                    w_src_hazard[j] = r_slot_is_load[i] && (i < LOAD_READY_STAGE);
                end
            end
        end
    end

    assign w_any_hazard = |w_src_hazard;
    // Flush wins over stall: the killed instruction needs no operands.
    assign w_stall      = i_dec_valid & w_any_hazard & ~i_flush;
    assign w_issue      = i_dec_valid & ~w_stall & ~i_flush;

    assign o_stall        = w_stall;
    assign o_issue        = w_issue;
    assign o_stall_cycles = r_stall_cycles;

    // -------------------------------------------------------------------------
    // Scoreboard advance. The scoreboard shifts every cycle. A cycle that does
    // not issue pushes a bubble, and older slots keep draining toward commit.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the slot arrays are reset explicitly. A stale valid bit
            // after reset would forward garbage or stall forever.
            for (int i = 0; i < FWD_DEPTH; i++) begin
                r_slot_valid[i]   <= 1'b0;
                r_slot_rd[i]      <= '0;
                r_slot_we[i]      <= 1'b0;
                r_slot_is_load[i] <= 1'b0;
            end
            r_stall_cycles <= '0;
        end else begin
            // NOTE: non-blocking assignments let every slot sample its
            // neighbour's pre-edge value, which gives a true shift register.
            for (int i = FWD_DEPTH - 1; i >= 1; i--) begin
                r_slot_valid[i]   <= r_slot_valid[i-1];
                r_slot_rd[i]      <= r_slot_rd[i-1];
                r_slot_we[i]      <= r_slot_we[i-1];
                r_slot_is_load[i] <= r_slot_is_load[i-1];
            end
            r_slot_valid[0]   <= w_issue;
            r_slot_rd[0]      <= i_dec_rd_addr;
            r_slot_we[0]      <= i_dec_rd_we & w_issue;
            r_slot_is_load[0] <= i_dec_is_load;

            if (w_stall && (r_stall_cycles != '1)) begin
                r_stall_cycles <= r_stall_cycles + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_hazard_forward_unit.sv
// -----------------------------------------------------------------------------
// tb_hazard_forward_unit
//
// Self-checking bench for hazard_forward_unit with default parameters.
// Each scenario task builds a small stimulus table. Every row carries its
// inputs and the outputs expected for them. Driving a row pushes its
// expectation onto the scoreboard. The task pops the expectation and compares
// it against the DUT outputs once the combinational outputs have settled,
// well away from the rising edge.
// -----------------------------------------------------------------------------
module tb_hazard_forward_unit;

    localparam logic [31:0] RF1 = 32'h5151_0001;
    localparam logic [31:0] RF0 = 32'h5050_0000;

    logic        clk;
    logic        rst;
    logic        dec_valid;
    logic [9:0]  dec_rs_addr;
    logic [1:0]  dec_rs_used;
    logic [4:0]  dec_rd_addr;
    logic        dec_rd_we;
    logic        dec_is_load;
    logic        flush;
    logic [63:0] rf_read_data;
    logic [95:0] stage_data;
    logic [63:0] operand_data;
    logic [3:0]  fwd_sel;
    logic        stall;
    logic        issue;
    logic [31:0] stall_cycles;

    int errors = 0;
    int checks = 0;

    hazard_forward_unit dut (
        .clk            (clk),
        .rst            (rst),
        .i_dec_valid    (dec_valid),
        .i_dec_rs_addr  (dec_rs_addr),
        .i_dec_rs_used  (dec_rs_used),
        .i_dec_rd_addr  (dec_rd_addr),
        .i_dec_rd_we    (dec_rd_we),
        .i_dec_is_load  (dec_is_load),
        .i_flush        (flush),
        .i_rf_read_data (rf_read_data),
        .i_stage_data   (stage_data),
        .o_operand_data (operand_data),
        .o_fwd_sel      (fwd_sel),
        .o_stall        (stall),
        .o_issue        (issue),
        .o_stall_cycles (stall_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    typedef struct packed {
        logic        stall;
        logic        issue;
        logic [3:0]  sel;
        logic [63:0] data;
        logic [31:0] cnt;
    } obs_t;

    typedef struct {
        string name;
        obs_t  val;
        obs_t  mask;
    } exp_t;

    typedef struct {
        string       name;
        logic        v;
        logic [4:0]  rs1, rs0;
        logic [1:0]  used;
        logic [4:0]  rd;
        logic        we, ld, fl;
        logic [31:0] s0, s1, s2;
        obs_t        val;
        obs_t        mask;
    } step_t;

    exp_t sb[$];

    function automatic obs_t observe();
        obs_t o;
        o.stall = stall;
        o.issue = issue;
        o.sel   = fwd_sel;
        o.data  = operand_data;
        o.cnt   = stall_cycles;
        return o;
    endfunction

    // care1/care0 = 0 marks an operand as don't-care (pending hazard).
    function automatic step_t mk(
        input string name, input logic v, input logic [4:0] rs1, input logic [4:0] rs0,
        input logic [1:0] used, input logic [4:0] rd, input logic we, input logic ld,
        input logic fl, input logic [31:0] s0, input logic [31:0] s1, input logic [31:0] s2,
        input logic e_stall, input logic e_issue, input logic [1:0] sel1, input logic [1:0] sel0,
        input logic [31:0] d1, input logic [31:0] d0, input logic care1, input logic care0,
        input logic [31:0] cnt);
        step_t s;
        s.name = name; s.v = v; s.rs1 = rs1; s.rs0 = rs0; s.used = used;
        s.rd = rd; s.we = we; s.ld = ld; s.fl = fl;
        s.s0 = s0; s.s1 = s1; s.s2 = s2;
        s.val  = '{stall: e_stall, issue: e_issue, sel: {sel1, sel0}, data: {d1, d0}, cnt: cnt};
        s.mask = '{stall: 1'b1, issue: 1'b1, sel: 4'hF,
                   data: {{32{care1}}, {32{care0}}}, cnt: 32'hFFFF_FFFF};
        return s;
    endfunction

    // Idle decode slot: no sources read, so operands come from the RF.
    function automatic step_t bubble(input string name, input logic [31:0] cnt);
        return mk(name, 1'b0, 5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 1'b0, 1'b0,
                  32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 2'd0, 2'd0, RF1, RF0, 1'b1, 1'b1, cnt);
    endfunction

    task automatic drive_step(input step_t s);
        exp_t e;
        dec_valid    = s.v;
        dec_rs_addr  = {s.rs1, s.rs0};
        dec_rs_used  = s.used;
        dec_rd_addr  = s.rd;
        dec_rd_we    = s.we;
        dec_is_load  = s.ld;
        flush        = s.fl;
        rf_read_data = {RF1, RF0};
        stage_data   = {s.s2, s.s1, s.s0};
        e.name = s.name; e.val = s.val; e.mask = s.mask;
        sb.push_back(e);
    endtask

    // ------------------------------------------------------------------------
    task automatic test_reset();
        exp_t e;
        obs_t o;
        step_t s;
        rst = 1'b1;
        s = mk("reset", 1'b1, 5'd5, 5'd6, 2'b11, 5'd7, 1'b1, 1'b1, 1'b0,
               32'h1, 32'h2, 32'h3, 1'b0, 1'b1, 2'd0, 2'd0, RF1, RF0, 1'b1, 1'b1, 32'd0);
        for (int k = 0; k < 2; k++) begin
            if (k == 0) #2;
            else begin @(negedge clk); #1; end
            if (k == 0) drive_step(s);
            else begin s.name = "reset_held_edge"; drive_step(s); #1; end
            if (k == 0) #1;
            e = sb.pop_front();
            o = observe();
            checks++;
            if ((o & e.mask) !== (e.val & e.mask)) begin
                errors++;
                $display("FAIL %s: got stall=%b issue=%b sel=%h data=%h cnt=%0d want stall=%b issue=%b sel=%h data=%h cnt=%0d",
                         e.name, o.stall, o.issue, o.sel, o.data, o.cnt,
                         e.val.stall, e.val.issue, e.val.sel, e.val.data, e.val.cnt);
            end
        end
        dec_valid = 1'b0;
        rst = 1'b0;
    endtask

    task automatic test_alu_back_to_back();
        step_t t[$];
        exp_t e;
        obs_t o;
        t.push_back(mk("alu_producer", 1, 0, 0, 2'b00, 5, 1, 0, 0, 32'h0, 32'h0, 32'h0,
                       0, 1, 0, 0, RF1, RF0, 1, 1, 0));
        t.push_back(mk("alu_consumer", 1, 5, 5, 2'b11, 6, 1, 0, 0, 32'h11, 32'h0, 32'h0,
                       0, 1, 1, 1, 32'h11, 32'h11, 1, 1, 0));
        for (int k = 0; k < 3; k++) t.push_back(bubble("alu_drain", 0));
        foreach (t[k]) begin
            @(negedge clk);
            drive_step(t[k]);
            #1;
            e = sb.pop_front();
            o = observe();
            checks++;
            if ((o & e.mask) !== (e.val & e.mask)) begin
                errors++;
                $display("FAIL %s: got stall=%b issue=%b sel=%h data=%h cnt=%0d want stall=%b issue=%b sel=%h data=%h cnt=%0d",
                         e.name, o.stall, o.issue, o.sel, o.data, o.cnt,
                         e.val.stall, e.val.issue, e.val.sel, e.val.data, e.val.cnt);
            end
        end
    endtask

    task automatic test_load_use();
        step_t t[$];
        exp_t e;
        obs_t o;
        t.push_back(mk("lu_load", 1, 0, 0, 2'b00, 7, 1, 1, 0, 32'h0, 32'h0, 32'h0,
                       0, 1, 0, 0, RF1, RF0, 1, 1, 0));
        t.push_back(mk("lu_stall", 1, 0, 7, 2'b11, 8, 1, 0, 0, 32'h0, 32'h0, 32'h0,
                       1, 0, 0, 1, RF1, 32'h0, 1, 0, 0));
        t.push_back(mk("lu_resume", 1, 0, 7, 2'b11, 8, 1, 0, 0, 32'h0, 32'hDEAD_BEEF, 32'h0,
                       0, 1, 0, 2, RF1, 32'hDEAD_BEEF, 1, 1, 1));
        for (int k = 0; k < 3; k++) t.push_back(bubble("lu_drain", 1));
        foreach (t[k]) begin
            @(negedge clk);
            drive_step(t[k]);
            #1;
            e = sb.pop_front();
            o = observe();
            checks++;
            if ((o & e.mask) !== (e.val & e.mask)) begin
                errors++;
                $display("FAIL %s: got stall=%b issue=%b sel=%h data=%h cnt=%0d want stall=%b issue=%b sel=%h data=%h cnt=%0d",
                         e.name, o.stall, o.issue, o.sel, o.data, o.cnt,
                         e.val.stall, e.val.issue, e.val.sel, e.val.data, e.val.cnt);
            end
        end
    endtask

    task automatic test_priority();
        step_t t[$];
        exp_t e;
        obs_t o;
        t.push_back(mk("pri_x9_a", 1, 0, 0, 2'b00, 9, 1, 0, 0, 32'h0, 32'h0, 32'h0,
                       0, 1, 0, 0, RF1, RF0, 1, 1, 1));
        t.push_back(mk("pri_x9_b", 1, 0, 0, 2'b00, 9, 1, 0, 0, 32'h0, 32'h0, 32'h0,
                       0, 1, 0, 0, RF1, RF0, 1, 1, 1));
        t.push_back(mk("pri_youngest", 1, 3, 9, 2'b01, 10, 1, 0, 0, 32'hB, 32'hA, 32'h0,
                       0, 1, 0, 1, RF1, 32'hB, 1, 1, 1));
        t.push_back(mk("pri_two_slots", 1, 10, 9, 2'b11, 0, 0, 0, 0, 32'hC, 32'hB, 32'hA,
                       0, 1, 1, 2, 32'hC, 32'hB, 1, 1, 1));
        for (int k = 0; k < 3; k++) t.push_back(bubble("pri_drain", 1));
        foreach (t[k]) begin
            @(negedge clk);
            drive_step(t[k]);
            #1;
            e = sb.pop_front();
            o = observe();
            checks++;
            if ((o & e.mask) !== (e.val & e.mask)) begin
                errors++;
                $display("FAIL %s: got stall=%b issue=%b sel=%h data=%h cnt=%0d want stall=%b issue=%b sel=%h data=%h cnt=%0d",
                         e.name, o.stall, o.issue, o.sel, o.data, o.cnt,
                         e.val.stall, e.val.issue, e.val.sel, e.val.data, e.val.cnt);
            end
        end
    endtask

    task automatic test_x0_and_unused();
        step_t t[$];
        exp_t e;
        obs_t o;
        t.push_back(mk("x0_producer", 1, 0, 0, 2'b00, 0, 1, 0, 0, 32'h0, 32'h0, 32'h0,
                       0, 1, 0, 0, RF1, RF0, 1, 1, 1));
        t.push_back(mk("x0_consumer", 1, 0, 0, 2'b11, 12, 1, 1, 0, 32'h77, 32'h0, 32'h0,
                       0, 1, 0, 0, RF1, RF0, 1, 1, 1));
        t.push_back(mk("unused_src", 1, 0, 12, 2'b00, 0, 0, 0, 0, 32'h88, 32'h77, 32'h0,
                       0, 1, 0, 0, RF1, RF0, 1, 1, 1));
        for (int k = 0; k < 3; k++) t.push_back(bubble("x0_drain", 1));
        foreach (t[k]) begin
            @(negedge clk);
            drive_step(t[k]);
            #1;
            e = sb.pop_front();
            o = observe();
            checks++;
            if ((o & e.mask) !== (e.val & e.mask)) begin
                errors++;
                $display("FAIL %s: got stall=%b issue=%b sel=%h data=%h cnt=%0d want stall=%b issue=%b sel=%h data=%h cnt=%0d",
                         e.name, o.stall, o.issue, o.sel, o.data, o.cnt,
                         e.val.stall, e.val.issue, e.val.sel, e.val.data, e.val.cnt);
            end
        end
    endtask

    task automatic test_flush_hazard();
        step_t t[$];
        exp_t e;
        obs_t o;
        t.push_back(mk("fl_load", 1, 0, 0, 2'b00, 13, 1, 1, 0, 32'h0, 32'h0, 32'h0,
                       0, 1, 0, 0, RF1, RF0, 1, 1, 1));
        t.push_back(mk("fl_kill", 1, 0, 13, 2'b01, 14, 1, 0, 1, 32'h0, 32'h0, 32'h0,
                       0, 0, 0, 1, RF1, 32'h0, 1, 0, 1));
        t.push_back(mk("fl_bubble", 1, 0, 13, 2'b01, 14, 1, 0, 0, 32'h0, 32'h1313, 32'h0,
                       0, 1, 0, 2, RF1, 32'h1313, 1, 1, 1));
        for (int k = 0; k < 3; k++) t.push_back(bubble("fl_drain", 1));
        foreach (t[k]) begin
            @(negedge clk);
            drive_step(t[k]);
            #1;
            e = sb.pop_front();
            o = observe();
            checks++;
            if ((o & e.mask) !== (e.val & e.mask)) begin
                errors++;
                $display("FAIL %s: got stall=%b issue=%b sel=%h data=%h cnt=%0d want stall=%b issue=%b sel=%h data=%h cnt=%0d",
                         e.name, o.stall, o.issue, o.sel, o.data, o.cnt,
                         e.val.stall, e.val.issue, e.val.sel, e.val.data, e.val.cnt);
            end
        end
    endtask

    task automatic test_async_reset_mid_stall();
        step_t t[$];
        exp_t e;
        obs_t o;
        t.push_back(mk("ar_load", 1, 0, 0, 2'b00, 15, 1, 1, 0, 32'h0, 32'h0, 32'h0,
                       0, 1, 0, 0, RF1, RF0, 1, 1, 1));
        t.push_back(mk("ar_stall", 1, 0, 15, 2'b01, 16, 1, 0, 0, 32'h0, 32'h0, 32'h0,
                       1, 0, 0, 1, RF1, 32'h0, 1, 0, 1));
        t.push_back(mk("ar_reset", 1, 0, 15, 2'b01, 16, 1, 0, 0, 32'h0, 32'h0, 32'h0,
                       0, 1, 0, 0, RF1, RF0, 1, 1, 0));
        foreach (t[k]) begin
            if (k < 2) begin
                @(negedge clk);
                drive_step(t[k]);
                #1;
            end else begin
                // Inputs stay as in the stalled cycle; reset lands between edges.
                #1;
                drive_step(t[k]);
                rst = 1'b1;
                #1;
            end
            e = sb.pop_front();
            o = observe();
            checks++;
            if ((o & e.mask) !== (e.val & e.mask)) begin
                errors++;
                $display("FAIL %s: got stall=%b issue=%b sel=%h data=%h cnt=%0d want stall=%b issue=%b sel=%h data=%h cnt=%0d",
                         e.name, o.stall, o.issue, o.sel, o.data, o.cnt,
                         e.val.stall, e.val.issue, e.val.sel, e.val.data, e.val.cnt);
            end
        end
        @(negedge clk);
        dec_valid = 1'b0;
        #1;
        rst = 1'b0;
    endtask

    // ------------------------------------------------------------------------
    initial begin
        rst          = 1'b1;
        dec_valid    = 1'b0;
        dec_rs_addr  = '0;
        dec_rs_used  = '0;
        dec_rd_addr  = '0;
        dec_rd_we    = 1'b0;
        dec_is_load  = 1'b0;
        flush        = 1'b0;
        rf_read_data = {RF1, RF0};
        stage_data   = '0;

        test_reset();
        test_alu_back_to_back();
        test_load_use();
        test_priority();
        test_x0_and_unused();
        test_flush_hazard();
        test_async_reset_mid_stall();

        if (sb.size() != 0) begin
            errors++;
            checks++;
            $display("FAIL scoreboard_leftover: got %0d entries want 0", sb.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
